// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexing scan controller for four common-anode seven-segment
//   displays. It walks a digit index 0..3, presents it to an external 4:1
//   pattern MUX, and samples the pattern at the end of a blanking gap. It
//   then lights that digit's anode for a fixed dwell. All outputs are
//   registered.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   enable     in   scan enable; low forces the display dark
//   digit_en   in   [3:0] per-digit enable mask, bit i = display i
//   mux_y      in   [6:0] pattern from the 4:1 MUX for mux_sel (active-low)
//   mux_sel    out  [1:0] select to the 4:1 MUX (current digit index)
//   seg        out  [6:0] segment drive, active-low
//   an         out  [3:0] anode drive, active-low one-hot
//   frame_tick out  one-cycle pulse at the start of each new frame
module seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit_en,
  input  logic [6:0] mux_y,
  output logic [1:0] mux_sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = 7'b111_1111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [6:0]    seg_q,   seg_d;
  logic [3:0]    an_q,    an_d;
  logic          tick_q,  tick_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      digit_q <= 2'd0;
      cnt_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  // Output registers are loaded with the values belonging to the state being
  // entered, so seg/an/mux_sel always line up with the registered state.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    an_d    = an_q;
    tick_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        digit_d = 2'd0;
        cnt_d   = '0;
        seg_d   = SEG_OFF;
        an_d    = AN_OFF;
        if (enable) begin
          state_d = BLANK;
        end
      end

      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          digit_d = 2'd0;
          cnt_d   = '0;
          seg_d   = SEG_OFF;
          an_d    = AN_OFF;
        end else if (cnt_q == BLANK_LAST) begin
          // The blanking gap doubles as MUX settling time: mux_sel has
          // been stable for the whole gap, so mux_y is sampled here and
          // held for the entire dwell. The mask bit is sampled likewise.
          state_d = SHOW;
          cnt_d   = '0;
          seg_d   = mux_y;
          an_d    = digit_en[digit_q] ? ~(4'b0001 << digit_q) : AN_OFF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHOW: begin
        if (!enable) begin
          state_d = IDLE;
          digit_d = 2'd0;
          cnt_d   = '0;
          seg_d   = SEG_OFF;
          an_d    = AN_OFF;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = BLANK;
          digit_d = digit_q + 2'd1;
          cnt_d   = '0;
          seg_d   = SEG_OFF;
          an_d    = AN_OFF;
          // Only the wrap from digit 3 marks a completed frame; entry
          // from IDLE never passes through here.
          tick_d  = (digit_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        digit_d = 2'd0;
        cnt_d   = '0;
        seg_d   = SEG_OFF;
        an_d    = AN_OFF;
      end
    endcase
  end

  assign mux_sel    = digit_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with DWELL_CYCLES=4, BLANK_CYCLES=2
//   (slot = 6 cycles, frame = 24 cycles). A behavioural 4:1 MUX feeds mux_y.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] digit_en;
  logic [6:0] mux_y;
  logic [1:0] mux_sel;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int vectors;
  int miscompares;
  logic chk_on;

  localparam logic [6:0] PAT_A  = 7'b0000010;
  localparam logic [6:0] PAT_B  = 7'b0000000;
  localparam logic [6:0] PAT_C0 = 7'b0000010;
  localparam logic [6:0] PAT_D  = 7'b0010010;
  localparam logic [6:0] PAT_C1 = 7'b1111000;

  logic [6:0] mux_c;

  seg_scan_ctrl #(
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digit_en  (digit_en),
    .mux_y     (mux_y),
    .mux_sel   (mux_sel),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board-level 4:1 pattern MUX
  always_comb begin
    case (mux_sel)
      2'd0:    mux_y = PAT_A;
      2'd1:    mux_y = PAT_B;
      2'd2:    mux_y = mux_c;
      default: mux_y = PAT_D;
    endcase
  end

  // Anode invariant, checked every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if ($countones(~an) > 1 || (seg == 7'h7F && an != 4'hF)) begin
        miscompares++;
        $display("FAIL anode_invariant t=%0t an=%b seg=%b (need <=1 low anode, none while blanked)",
                 $time, an, seg);
      end
    end
  end

  // Expected {frame_tick, mux_sel, an, seg} for cycle t counted from the
  // first BLANK cycle after enabling; pc is the digit-2 pattern in effect.
  function automatic logic [13:0] model(int t, logic [3:0] den, logic [6:0] pc);
    int         slot;
    int         pos;
    logic       tk;
    logic [6:0] pat;
    logic [3:0] a;
    slot = (t / 6) % 4;
    pos  = t % 6;
    tk   = (t > 0) && (t % 24 == 0);
    case (slot)
      0:       pat = PAT_A;
      1:       pat = PAT_B;
      2:       pat = pc;
      default: pat = PAT_D;
    endcase
    if (pos < 2) return {tk, 2'(slot), 4'hF, 7'h7F};
    a = den[slot] ? ~(4'b0001 << slot) : 4'hF;
    return {1'b0, 2'(slot), a, pat};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    cycle();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    reset    = 1'b1;
    enable   = 1'b1;
    digit_en = 4'hF;
    cycle();
    cycle();
    chk_on = 1'b1;
    obs = {frame_tick, mux_sel, an, seg};
    vectors++;
    if (obs !== {1'b0, 2'b00, 4'hF, 7'h7F}) begin
      miscompares++;
      $display("FAIL reset_values got=%b want=%b", obs, {1'b0, 2'b00, 4'hF, 7'h7F});
    end
    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      vectors++;
      if (obs !== {1'b0, 2'b00, 4'hF, 7'h7F}) begin
        miscompares++;
        $display("FAIL idle_hold cyc=%0d got=%b want=%b", i, obs, {1'b0, 2'b00, 4'hF, 7'h7F});
      end
    end
  endtask

  task automatic test_full_frame();
    logic [13:0] obs, exp;
    int ticks;
    ticks    = 0;
    do_reset();
    digit_en = 4'hF;
    enable   = 1'b1;
    for (int t = 0; t < 49; t++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      exp = model(t, 4'hF, PAT_C0);
      if (frame_tick === 1'b1) ticks++;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL full_frame t=%0d got=%b want=%b", t, obs, exp);
      end
    end
    vectors++;
    if (ticks !== 2) begin
      miscompares++;
      $display("FAIL frame_tick_count got=%0d want=2", ticks);
    end
  endtask

  task automatic test_digit_mask();
    logic [13:0] obs, exp;
    do_reset();
    digit_en = 4'b1011;
    enable   = 1'b1;
    for (int t = 0; t < 49; t++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      exp = model(t, 4'b1011, PAT_C0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL digit_mask t=%0d got=%b want=%b", t, obs, exp);
      end
    end
    digit_en = 4'hF;
  endtask

  task automatic test_mux_hold();
    logic [13:0] obs, exp;
    do_reset();
    digit_en = 4'hF;
    enable   = 1'b1;
    for (int t = 0; t < 48; t++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      exp = model(t, 4'hF, (t < 24) ? PAT_C0 : PAT_C1);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mux_hold t=%0d got=%b want=%b", t, obs, exp);
      end
      // Second SHOW cycle of digit 2: change the MUX C input
      if (t == 15) mux_c = PAT_C1;
    end
    mux_c = PAT_C0;
  endtask

  task automatic test_enable_drop();
    logic [13:0] obs, exp;
    do_reset();
    digit_en = 4'hF;
    enable   = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      exp = model(t, 4'hF, PAT_C0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL pre_drop t=%0d got=%b want=%b", t, obs, exp);
      end
    end
    // Enable low during the 2nd SHOW cycle of digit 1
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      vectors++;
      if (obs !== {1'b0, 2'b00, 4'hF, 7'h7F}) begin
        miscompares++;
        $display("FAIL enable_drop cyc=%0d got=%b want=%b", i, obs, {1'b0, 2'b00, 4'hF, 7'h7F});
      end
    end
    enable = 1'b1;
    for (int t = 0; t < 25; t++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      exp = model(t, 4'hF, PAT_C0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL re_enable t=%0d got=%b want=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    logic [13:0] obs, exp;
    do_reset();
    digit_en = 4'hF;
    enable   = 1'b1;
    for (int t = 0; t < 16; t++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      exp = model(t, 4'hF, PAT_C0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL pre_reset t=%0d got=%b want=%b", t, obs, exp);
      end
    end
    reset = 1'b1;
    cycle();
    obs = {frame_tick, mux_sel, an, seg};
    vectors++;
    if (obs !== {1'b0, 2'b00, 4'hF, 7'h7F}) begin
      miscompares++;
      $display("FAIL reset_mid_show got=%b want=%b", obs, {1'b0, 2'b00, 4'hF, 7'h7F});
    end
    reset = 1'b0;
    for (int t = 0; t < 14; t++) begin
      cycle();
      obs = {frame_tick, mux_sel, an, seg};
      exp = model(t, 4'hF, PAT_C0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL post_reset t=%0d got=%b want=%b", t, obs, exp);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_on      = 1'b0;
    reset       = 1'b1;
    enable      = 1'b0;
    digit_en    = 4'hF;
    mux_c       = PAT_C0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_digit_mask();
    test_mux_hold();
    test_enable_drop();
    test_reset_mid_show();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scan controller for the four common-anode seven-segment displays.
- Drives the select input of the existing 4:1 seven-bit pattern MUX and samples the MUX output.
- Drives the shared segment bus and the four active-low anode lines, with a blanking gap between digits to prevent ghosting.
- Sits between the pattern registers/MUX and the board pins.

Parameters:
- DWELL_CYCLES, 50000: clock cycles each digit is lit (SHOW). Must be >= 1.
- BLANK_CYCLES, 500: clock cycles all anodes are off before each digit (BLANK). Must be >= 1; also serves as the MUX settling time.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable; low forces the display dark.
- digit_en  input  4  per-digit enable mask; bit i = display i.
- mux_y  input  7  pattern returned by the 4:1 MUX for the current mux_sel (active-low segments).
- mux_sel  output  2  select to the 4:1 MUX = current digit index.
- seg  output  7  segment drive, active-low (1 = segment off).
- an  output  4  anode drive, active-low one-hot (1111 = all off).
- frame_tick  output  1  one-cycle pulse each completed 4-digit frame.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset (reset high at a clk edge):
  - state = IDLE; digit = 0; counter = 0.
  - mux_sel = 00, an = 1111, seg = 1111111, frame_tick = 0.
  - reset wins over every other input.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs held at their reset values.
  - If enable = 1, next cycle enter BLANK with digit = 0 and counter = 0.
- BLANK:
  - an = 1111, seg = 1111111, mux_sel = digit.
  - Lasts exactly BLANK_CYCLES cycles.
  - On the last BLANK cycle, latch mux_y into the segment register and latch digit_en[digit]; then enter SHOW with counter = 0.
- SHOW:
  - seg = latched pattern, constant for the whole dwell; mux_y changes during SHOW are ignored.
  - an[digit] = 0 if the latched enable bit = 1, else an = 1111. A disabled digit still consumes its full time slot, keeping duty cycle and brightness constant.
  - Lasts exactly DWELL_CYCLES cycles, then enter BLANK with digit = (digit + 1) mod 4 (3 wraps to 0).
- Slot timing: one digit slot = BLANK_CYCLES + DWELL_CYCLES cycles; one frame = 4 × slot.
- Counter width: $clog2(max(DWELL_CYCLES, BLANK_CYCLES) + 1); counts 0..N-1, no overflow.
- frame_tick:
  - High for exactly the first BLANK cycle of digit 0 that follows SHOW of digit 3.
  - Not asserted on the first BLANK after leaving IDLE.
- enable deasserted in BLANK or SHOW:
  - Next cycle enter IDLE; an = 1111, seg = 1111111, mux_sel = 00, frame_tick = 0.
  - A partial frame is abandoned; re-enable restarts at digit 0.
- digit_en changes mid-SHOW take effect from the next slot only.
- Anode one-hot invariant: at most one an bit is 0 in any cycle, and it is never low during BLANK or IDLE.

Test Plan:
(Benches use DWELL_CYCLES=4, BLANK_CYCLES=2; MUX model with A=0000010, B=0000000, C=0000010, D=0010010.)
- Reset, then enable=1, digit_en=1111 → 2 cycles BLANK (an=1111, seg=1111111, mux_sel=00); then 4 cycles an=1110, seg=0000010; then BLANK with mux_sel=01.
- Run a full frame → digit order 0,1,2,3,0; an=1110,1101,1011,0111; seg=0000010,0000000,0000010,0010010. frame_tick high exactly once, on the 25th cycle after the first BLANK began (start of digit-0 BLANK following digit 3).
- digit_en=1011 → digit 2 slot shows an=1111 for all 6 cycles; digits 0, 1 and 3 unaffected; frame period unchanged at 24 cycles.
- Change the MUX C input to 1111000 during digit 2 SHOW → seg stays 0000010 for the remainder of that SHOW; next digit-2 slot shows 1111000.
- Drop enable in the 2nd SHOW cycle of digit 1 → next cycle an=1111, seg=1111111, mux_sel=00. Re-enable → restart at digit 0 BLANK, no frame_tick.
- Assert reset together with enable=1 mid-SHOW → next cycle all outputs at reset values, state IDLE. Release reset with enable=1 → scan restarts at digit 0.
- Checker throughout: at most one an bit low; never low while seg=1111111 is being driven in BLANK.
